// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package uart_pkg;

   // Serialiser states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   // Register select (data_address[3:2])
   localparam logic [1:0] UART_TXDATA = 2'd0;
   localparam logic [1:0] UART_STATUS = 2'd1;
   localparam logic [1:0] UART_BAUD   = 2'd2;

   // STATUS bit positions
   localparam int unsigned STAT_BUSY      = 0;
   localparam int unsigned STAT_FULL      = 1;
   localparam int unsigned STAT_EMPTY     = 2;
   localparam int unsigned STAT_OVERFLOW  = 3;
   localparam int unsigned STAT_COUNT_LSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fall-through read data. A push while full is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [WIDTH-1:0]         i_wdata,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
   localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == CNT_MAX);
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   // Storage array, no reset needed
   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointers and occupancy
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decode, control registers, TX FIFO
// and the serialiser FSM.
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter logic [15:0] BAUD_DEFAULT = 16'd868
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_data_require,
   input  logic        i_data_write_enable,
   input  logic [3:0]  i_data_byte_enable_map,
   input  logic [31:0] i_data_address,
   input  logic [31:0] i_data_write,
   output logic [31:0] o_data_read,
   output logic        o_tx,
   output logic        o_irq_tx_empty
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   uart_state_t r_state;
   uart_state_t w_state_next;

   logic [7:0]    r_shift;
   logic [15:0]   r_bit_period;
   logic [15:0]   r_timer;
   logic [2:0]    r_bit_cnt;
   logic [15:0]   r_baud_div;
   logic          r_overflow;
   logic [31:0]   r_data_read;
   logic          r_irq;

   logic          w_hit;
   logic          w_load;
   logic          w_store;
   logic [1:0]    w_sel;
   logic          w_txdata_wr;
   logic          w_push;
   logic          w_pop;
   logic          w_timer_done;
   logic [15:0]   w_period_new;
   logic          w_tx;
   logic          w_busy;
   logic [31:0]   w_rdata_mux;
   logic [7:0]    w_fifo_rdata;
   logic          w_fifo_full;
   logic          w_fifo_empty;
   logic [CW-1:0] w_fifo_count;

   assign w_hit        = i_data_require && (i_data_address[31:4] == BASE_ADDR[31:4]);
   assign w_load       = w_hit && !i_data_write_enable;
   assign w_store      = w_hit && i_data_write_enable;
   assign w_sel        = i_data_address[3:2];
   assign w_txdata_wr  = w_store && (w_sel == UART_TXDATA) && i_data_byte_enable_map[0];
   // The serialiser's pop frees a slot in the same cycle, so a full FIFO can still accept
   assign w_push       = w_txdata_wr && (!w_fifo_full || w_pop);
   assign w_timer_done = (r_timer == 16'd0);
   assign w_period_new = (r_baud_div == 16'd0) ? 16'd1 : r_baud_div;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (i_data_write[7:0]),
      .o_rdata (w_fifo_rdata),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   // FSM state register
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= IDLE;
      else         r_state <= w_state_next;
   end

   // FSM next state; a pop always coincides with entering START
   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_fifo_empty) begin
               w_state_next = START;
               w_pop        = 1'b1;
            end
         end
         START: begin
            if (w_timer_done) w_state_next = DATA;
         end
         DATA: begin
            if (w_timer_done && (r_bit_cnt == 3'd7)) w_state_next = STOP;
         end
         STOP: begin
            if (w_timer_done) begin
               if (!w_fifo_empty) begin
                  w_state_next = START;
                  w_pop        = 1'b1;
               end else begin
                  w_state_next = IDLE;
               end
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      w_tx   = 1'b1;
      w_busy = (r_state != IDLE);
      case (r_state)
         START:   w_tx = 1'b0;
         DATA:    w_tx = r_shift[0];
         default: w_tx = 1'b1;
      endcase
   end

   // Serialiser datapath; the bit period is latched per frame so baud writes wait
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_shift      <= '0;
         r_bit_period <= 16'd1;
         r_timer      <= '0;
         r_bit_cnt    <= '0;
      end else if (w_pop) begin
         r_shift      <= w_fifo_rdata;
         r_bit_period <= w_period_new;
         r_timer      <= w_period_new - 16'd1;
         r_bit_cnt    <= '0;
      end else if (r_state != IDLE) begin
         if (w_timer_done) begin
            r_timer <= r_bit_period - 16'd1;
            if (r_state == DATA) begin
               r_shift   <= {1'b0, r_shift[7:1]};
               r_bit_cnt <= r_bit_cnt + 3'd1;
            end
         end else begin
            r_timer <= r_timer - 16'd1;
         end
      end
   end

   // Load data selection
   always_comb begin
      w_rdata_mux = '0;
      case (w_sel)
         UART_STATUS: begin
            w_rdata_mux[STAT_BUSY]     = w_busy;
            w_rdata_mux[STAT_FULL]     = w_fifo_full;
            w_rdata_mux[STAT_EMPTY]    = w_fifo_empty;
            w_rdata_mux[STAT_OVERFLOW] = r_overflow;
            w_rdata_mux[STAT_COUNT_LSB +: 8] = 8'(w_fifo_count);
         end
         UART_BAUD: w_rdata_mux[15:0] = r_baud_div;
         default:   w_rdata_mux = '0;
      endcase
   end

   // Control registers, load data and interrupt
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_baud_div  <= BAUD_DEFAULT;
         r_overflow  <= 1'b0;
         r_data_read <= '0;
         r_irq       <= 1'b1;
      end else begin
         r_irq <= w_fifo_empty && (r_state == IDLE);
         if (w_txdata_wr && w_fifo_full && !w_pop) begin
            r_overflow <= 1'b1;
         end else if (w_store && (w_sel == UART_STATUS) && i_data_byte_enable_map[0]
                      && i_data_write[STAT_OVERFLOW]) begin
            r_overflow <= 1'b0;
         end
         if (w_store && (w_sel == UART_BAUD)) begin
            if (i_data_byte_enable_map[0]) r_baud_div[7:0]  <= i_data_write[7:0];
            if (i_data_byte_enable_map[1]) r_baud_div[15:8] <= i_data_write[15:8];
         end
         if (w_load) r_data_read <= w_rdata_mux;
      end
   end

   assign o_data_read    = r_data_read;
   assign o_tx           = w_tx;
   assign o_irq_tx_empty = r_irq;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: bytes are queued as expected when stored
// and compared against frames decoded from the tx pin.
module tb_mmio_uart_tx;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] data_read;
   logic        tx;
   logic        irq;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   mmio_uart_tx #(
      .BASE_ADDR    (32'h0000_1000),
      .FIFO_DEPTH   (8),
      .BAUD_DEFAULT (16'd868)
   ) dut (
      .i_clk                  (clk),
      .i_reset                (reset),
      .i_data_require         (req),
      .i_data_write_enable    (we),
      .i_data_byte_enable_map (be),
      .i_data_address         (addr),
      .i_data_write           (wdata),
      .o_data_read            (data_read),
      .o_tx                   (tx),
      .o_irq_tx_empty         (irq)
   );

   // One-cycle bus store, driven between active edges
   task automatic bus_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
      @(negedge clk);
      req = 1'b0; we = 1'b0;
   endtask

   // One-cycle bus load; data_read is valid when this returns
   task automatic bus_load(input logic [31:0] a);
      req = 1'b1; we = 1'b0; addr = a; be = 4'h0;
      @(negedge clk);
      req = 1'b0;
   endtask

   // Decode one 8N1 frame sampled on falling edges; gap = idle samples before start
   task automatic capture_frame(input int period, input int timeout, output logic [7:0] b,
                                output int gap, output bit ok);
      logic v;
      gap = 0;
      ok  = 1'b1;
      b   = 8'h00;
      @(negedge clk);
      while (tx !== 1'b0) begin
         gap++;
         if (gap > timeout) begin
            ok = 1'b0;
            return;
         end
         @(negedge clk);
      end
      for (int i = 1; i < period; i++) begin
         @(negedge clk);
         if (tx !== 1'b0) ok = 1'b0;
      end
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         v    = tx;
         b[j] = v;
         for (int i = 1; i < period; i++) begin
            @(negedge clk);
            if (tx !== v) ok = 1'b0;
         end
      end
      for (int i = 0; i < period; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) ok = 1'b0;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (tx !== 1'b1) begin
         n_errors++; $display("FAIL reset_tx: got %b want 1", tx);
      end
      n_checks++;
      if (irq !== 1'b1) begin
         n_errors++; $display("FAIL reset_irq: got %b want 1", irq);
      end
      n_checks++;
      if (data_read !== 32'h0) begin
         n_errors++; $display("FAIL reset_data_read: got %h want 0", data_read);
      end
      bus_load(32'h1004);
      n_checks++;
      if (data_read !== 32'h0000_0004) begin
         n_errors++; $display("FAIL reset_status: got %h want 00000004", data_read);
      end
   endtask

   task automatic test_single_frame();
      logic [7:0] b;
      logic [7:0] want;
      int gap;
      bit ok;
      bus_store(32'h1008, 32'd4, 4'b0011);
      exp_q.push_back(8'hA5);
      bus_store(32'h1000, 32'hA5, 4'b0001);
      fork
         capture_frame(4, 20, b, gap, ok);
         begin
            repeat (10) @(negedge clk);
            n_checks++;
            if (irq !== 1'b0) begin
               n_errors++; $display("FAIL single_irq_busy: got %b want 0", irq);
            end
         end
      join
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      n_checks++;
      if (b !== want || !ok) begin
         n_errors++; $display("FAIL single_frame: got %h shape_ok=%0d want %h shape_ok=1", b, ok, want);
      end
      // irq is registered: one edge for the FSM to reach IDLE, one more for irq
      @(negedge clk);
      n_checks++;
      if (irq !== 1'b0) begin
         n_errors++; $display("FAIL single_irq_lag: got %b want 0", irq);
      end
      @(negedge clk);
      n_checks++;
      if (irq !== 1'b1) begin
         n_errors++; $display("FAIL single_irq_empty: got %b want 1", irq);
      end
   endtask

   // First byte is popped the cycle after it is stored, so all nine fit
   task automatic test_back_to_back();
      logic [7:0] b;
      logic [7:0] want;
      int gap;
      bit ok;
      bus_store(32'h1008, 32'd2, 4'b0011);
      fork
         begin
            for (int i = 0; i < 9; i++) begin
               exp_q.push_back(8'h30 + 8'(i * 7));
               bus_store(32'h1000, 32'h30 + 32'(i * 7), 4'b0001);
            end
            bus_load(32'h1004);
            n_checks++;
            if (data_read !== 32'h0000_0803) begin
               n_errors++; $display("FAIL b2b_status: got %h want 00000803", data_read);
            end
         end
         begin
            for (int f = 0; f < 9; f++) begin
               capture_frame(2, 40, b, gap, ok);
               want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
               n_checks++;
               if (b !== want || !ok || (f > 0 && gap != 0)) begin
                  n_errors++;
                  $display("FAIL b2b_frame%0d: got %h ok=%0d gap=%0d want %h ok=1 gap=0",
                           f, b, ok, gap, want);
               end
            end
         end
      join
      repeat (3) @(negedge clk);
   endtask

   // Nine bytes fill serialiser plus FIFO; the tenth overflows
   task automatic test_overflow();
      logic [7:0] b;
      logic [7:0] want;
      int gap;
      bit ok;
      bus_store(32'h1008, 32'd1000, 4'b0011);
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               if (i < 9) exp_q.push_back(8'hC0 + 8'(i));
               bus_store(32'h1000, 32'hC0 + 32'(i), 4'b0001);
            end
            bus_load(32'h1004);
            n_checks++;
            if (data_read !== 32'h0000_080B) begin
               n_errors++; $display("FAIL ovf_status_set: got %h want 0000080b", data_read);
            end
            bus_store(32'h1004, 32'h8, 4'b0001);
            bus_load(32'h1004);
            n_checks++;
            if (data_read !== 32'h0000_0803) begin
               n_errors++; $display("FAIL ovf_status_clear: got %h want 00000803", data_read);
            end
            bus_store(32'h1008, 32'd3, 4'b0011);
         end
         begin
            for (int f = 0; f < 9; f++) begin
               capture_frame((f == 0) ? 1000 : 3, 40, b, gap, ok);
               want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
               n_checks++;
               if (b !== want || !ok || (f > 0 && gap != 0)) begin
                  n_errors++;
                  $display("FAIL ovf_frame%0d: got %h ok=%0d gap=%0d want %h ok=1 gap=0",
                           f, b, ok, gap, want);
               end
            end
            capture_frame(3, 40, b, gap, ok);
            n_checks++;
            if (ok) begin
               n_errors++; $display("FAIL ovf_extra_frame: got byte %h want none", b);
            end
         end
      join
   endtask

   // baud 0 acts as 1; a baud write mid-frame applies from the next frame
   task automatic test_baud_change();
      logic [7:0] b;
      logic [7:0] want;
      int gap;
      bit ok;
      bus_store(32'h1008, 32'd0, 4'b0011);
      fork
         begin
            exp_q.push_back(8'hFF);
            bus_store(32'h1000, 32'hFF, 4'b0001);
            @(negedge clk);
            bus_store(32'h1008, 32'd16, 4'b0011);
            exp_q.push_back(8'h3C);
            bus_store(32'h1000, 32'h3C, 4'b0001);
         end
         begin
            capture_frame(1, 20, b, gap, ok);
            want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            n_checks++;
            if (b !== want || !ok) begin
               n_errors++; $display("FAIL baud0_frame: got %h ok=%0d want %h ok=1", b, ok, want);
            end
            capture_frame(16, 20, b, gap, ok);
            want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            n_checks++;
            if (b !== want || !ok || gap != 0) begin
               n_errors++;
               $display("FAIL baud16_frame: got %h ok=%0d gap=%0d want %h ok=1 gap=0",
                        b, ok, gap, want);
            end
         end
      join
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid_frame();
      int lows;
      bus_store(32'h1008, 32'd4, 4'b0011);
      bus_store(32'h1000, 32'h00, 4'b0001);
      bus_store(32'h1000, 32'h55, 4'b0001);
      repeat (9) @(negedge clk);
      n_checks++;
      if (tx !== 1'b0) begin
         n_errors++; $display("FAIL midframe_precond: got tx=%b want 0", tx);
      end
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if (tx !== 1'b1) begin
         n_errors++; $display("FAIL midframe_tx: got %b want 1", tx);
      end
      reset = 1'b0;
      bus_load(32'h1004);
      n_checks++;
      if (data_read !== 32'h0000_0004) begin
         n_errors++; $display("FAIL midframe_status: got %h want 00000004", data_read);
      end
      lows = 0;
      repeat (200) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      n_checks++;
      if (lows != 0) begin
         n_errors++; $display("FAIL midframe_no_frame: got %0d low samples want 0", lows);
      end
   endtask

   task automatic test_decode();
      int lows;
      lows = 0;
      bus_load(32'h1008);
      n_checks++;
      if (data_read !== 32'd868) begin
         n_errors++; $display("FAIL baud_default: got %h want 00000364", data_read);
      end
      bus_store(32'h2000, 32'h77, 4'hF);
      if (tx !== 1'b1) lows++;
      bus_load(32'h2004);
      n_checks++;
      if (data_read !== 32'd868) begin
         n_errors++; $display("FAIL outside_load: got %h want 00000364", data_read);
      end
      bus_store(32'h1000, 32'h12, 4'b1110);
      if (tx !== 1'b1) lows++;
      bus_store(32'h100C, 32'hFFFF_FFFF, 4'hF);
      bus_load(32'h1004);
      n_checks++;
      if (data_read !== 32'h0000_0004) begin
         n_errors++; $display("FAIL outside_no_push: got %h want 00000004", data_read);
      end
      n_checks++;
      if (lows != 0 || tx !== 1'b1) begin
         n_errors++; $display("FAIL outside_tx_idle: got %0d low samples want 0", lows);
      end
      bus_load(32'h100C);
      n_checks++;
      if (data_read !== 32'h0) begin
         n_errors++; $display("FAIL reserved_load: got %h want 0", data_read);
      end
      bus_store(32'h1008, 32'h0000_ABCD, 4'b0010);
      bus_load(32'h1008);
      n_checks++;
      if (data_read !== 32'h0000_AB64) begin
         n_errors++; $display("FAIL baud_lane: got %h want 0000ab64", data_read);
      end
      bus_load(32'h1000);
      n_checks++;
      if (data_read !== 32'h0) begin
         n_errors++; $display("FAIL txdata_load: got %h want 0", data_read);
      end
   endtask

   initial begin
      reset = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0; addr = '0; wdata = '0;
      @(negedge clk);
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_overflow();
      test_baud_change();
      test_reset_mid_frame();
      test_decode();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
